// File: rtl/lfsr.sv
// 24-bit maximal-length Fibonacci LFSR (x^24+x^23+x^22+x^17+1) with a
// selectable seed: each value of num starts its own repeatable sequence.
module lfsr #(
  parameter logic [23:0] SEED = 24'h000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  num,
  output logic [23:0] out
);

  logic [23:0] state;
  logic [23:0] state_nxt;
  logic [3:0]  num_q;
  logic [3:0]  seed_idx;
  logic        reseed;
  logic        fb;

  function automatic logic [23:0] rotl24(input logic [23:0] v, input logic [3:0] n);
    logic [47:0] d;
    d = {v, v} << n;
    return d[47:24];
  endfunction

  always_comb begin
    fb        = state[23] ^ state[22] ^ state[21] ^ state[16];
    reseed    = rst || (num != num_q) || (state == 24'h000000);
    // the lock-up guard only wins when num==num_q, so num selects the seed in every reseed case
    seed_idx  = (rst || (num != num_q)) ? num : num_q;
    state_nxt = {state[22:0], fb};
    if (reseed) begin
      state_nxt = rotl24(SEED, seed_idx);
    end
  end

  // num_q takes num on every edge: on reset or change it must, otherwise they already match
  always_ff @(posedge clk) begin
    state <= state_nxt;
    num_q <= num;
  end

  assign out = state;

endmodule

// File: tb/tb_lfsr.sv
// Directed and randomized checks of lfsr against a polynomial-level reference
// model (seed by arithmetic rotation, feedback as parity of tapped bits).
module tb_lfsr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  num;
  logic [23:0] out;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] BASE = 24'h000001;

  lfsr #(.SEED(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .num (num),
    .out (out)
  );

  always #5 clk = ~clk;

  // reference model
  int unsigned m_s;
  int unsigned m_q;

  function automatic int unsigned ref_seed(input int unsigned n);
    int unsigned b;
    b = int'(BASE);
    return ((b << n) | (b >> (24 - n))) & 32'h00FF_FFFF;
  endfunction

  function automatic int unsigned ref_step(input int unsigned s);
    int unsigned taps;
    int unsigned par;
    taps = s & 32'h00E1_0000;
    par  = 0;
    for (int i = 0; i < 24; i++) par = par + ((taps >> i) & 1);
    return ((s << 1) & 32'h00FF_FFFF) | (par % 2);
  endfunction

  function automatic void model_edge(input logic r, input logic [3:0] n);
    if (r || (int'(n) != m_q)) begin
      m_s = ref_seed(int'(n));
      m_q = int'(n);
    end else if (m_s == 0) begin
      m_s = ref_seed(m_q);
    end else begin
      m_s = ref_step(m_s);
    end
  endfunction

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // inputs are already set; take one rising edge, update model, sample at the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge(rst, num);
    @(negedge clk);
  endtask

  logic [23:0] run9 [0:7];
  logic [23:0] e;

  initial begin
    m_s = 0;
    m_q = 0;
    rst = 1'b1;
    num = 4'd9;

    // reset holds seed(9)
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_seed9", out, 24'h000200);
    end

    // shift sequence after release
    rst = 1'b0;
    for (int k = 0; k < 7; k++) run9[k] = 24'h000400 << k;
    run9[7] = 24'h020001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("shift9", out, run9[k]);
    end

    // selector change reseeds without shifting
    num = 4'd0;
    tick();
    chk("reseed0", out, 24'h000001);
    tick();
    chk("step_after_reseed", out, 24'h000002);

    // mid-run reset after 37 steps
    num = 4'd9;
    tick();
    chk("reseed9", out, 24'h000200);
    repeat (37) tick();
    chk("run37_model", out, m_s[23:0]);
    rst = 1'b1;
    tick();
    chk("midrun_reset", out, 24'h000200);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("repeat9", out, run9[k]);
    end

    // lock-up guard
    num = 4'd3;
    tick();
    chk("reseed3", out, 24'h000008);
    repeat (5) tick();
    force dut.state = 24'h000000;
    #1;
    release dut.state;
    #1;
    chk("forced_zero", out, 24'h000000);
    m_s = 0;
    tick();
    chk("lockup_recover", out, 24'h000008);

    // randomized run against the model
    rst = 1'b1;
    num = 4'($urandom_range(0, 15));
    tick();
    chk("rand_reset", out, m_s[23:0]);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) num = 4'($urandom_range(0, 15));
      tick();
      e = m_s[23:0];
      chk("rand_model", out, e);
      if (out == 24'h000000) chk("never_zero", out, 24'hFFFFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
